// File: rtl/fifo_reader.sv
// Read-side controller for the project FIFO: pops words, hides the FIFO's
// one-cycle read latency and presents them downstream on a valid/ready port.
module fifo_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   Enable,
    input  logic [DATA_WIDTH-1:0]  FIFO_data_out,
    input  logic                   FIFO_empty,
    input  logic                   FIFO_almost_empty,
    output logic                   read_enable,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   low_water,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] word_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic                  pend;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;
    logic [DATA_WIDTH-1:0] slot0_next;
    logic [DATA_WIDTH-1:0] slot1_next;
    logic                  pop;
    logic [2:0]            free;
    logic                  lw_q;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + COUNT_WIDTH'(1);
    endfunction

    assign pop       = valid_out & ready_in;
    // A pop this cycle frees a slot for the word arriving next cycle.
    assign free      = 3'd2 - {1'b0, occ} - {2'b0, pend} + {2'b0, pop};
    assign read_enable = Reset & (state == RUN) & ~FIFO_empty & (free != 3'd0);

    assign valid_out = (occ != 2'd0);
    assign data_out  = slot0;
    assign busy      = (state != IDLE);
    assign low_water = lw_q & busy;

    always_comb begin
        slot0_next = slot0;
        slot1_next = slot1;
        occ_next   = occ + {1'b0, pend} - {1'b0, pop};
        if (pop) begin
            slot0_next = slot1;
        end
        // The arriving word lands right behind whatever survives this pop.
        if (pend) begin
            if (occ > {1'b0, pop}) begin
                slot1_next = FIFO_data_out;
            end else begin
                slot0_next = FIFO_data_out;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!Enable) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (Enable) begin
                    state_next = RUN;
                end else if ((occ == 2'd0) && !pend) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state      <= IDLE;
            occ        <= 2'd0;
            pend       <= 1'b0;
            word_count <= '0;
            lw_q       <= 1'b0;
            slot0      <= '0;
            slot1      <= '0;
        end else begin
            state <= state_next;
            occ   <= occ_next;
            pend  <= read_enable;
            slot0 <= slot0_next;
            slot1 <= slot1_next;
            lw_q  <= FIFO_almost_empty;
            if (pop) begin
                word_count <= sat_inc(word_count);
            end
        end
    end

endmodule
